pc_sequencer: RTL
=================

# pc_sequencer

Program-counter and vector sequencer for the single-cycle MIPS core. Owns the PC register that drives the instruction ROM address, selects the next PC from sequential, branch, jump, and register-jump sources, and diverts fetch to the interrupt vector (0x80000004) or the exception vector (0x80000008). On every vector entry it saves the return address to $k0. Sits between the control/ALU decode and the ROM fetch port, and receives the timer interrupt line from the peripheral bus.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset (kernel mode, ROM word 0)
- IRQ_VEC, 32'h8000_0004, interrupt entry address
- EXC_VEC, 32'h8000_0008, exception entry address

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  freeze: PC, kernel bit and entry decisions do not advance
- irq  in  1  timer interrupt request from the peripheral bus
- exc  in  1  exception from decode (undefined opcode); valid for the current PC
- br_taken  in  1  conditional branch taken
- br_target  in  32  branch target (PC+4+offset<<2, computed by the ALU path)
- j_en  in  1  j/jal
- j_target  in  26  instruction index field
- jr_en  in  1  jr/jalr
- jr_target  in  32  rs value
- pc  out  32  current PC to the ROM address and to the jal link path
- pc_plus4  out  32  pc+4
- flush  out  1  squash register/memory writes of the current instruction
- k0_we  out  1  write $k0 this cycle
- k0_wdata  out  32  return address for $k0
- kernel  out  1  equals pc[31]; interrupts are masked while it is 1
- irq_pending  out  1  interrupt latched but not yet taken

## Operation
- Next-PC priority, highest first: exc, accepted interrupt, jr_en, j_en, br_taken, pc+4.
- The interrupt is accepted when the pending condition is true, kernel==0, exc==0 and hold==0.
- Exception entry:
  - flush=1, k0_we=1, k0_wdata=pc+4; the faulting instruction is skipped on return.
  - next pc=EXC_VEC.
  - Exceptions are taken even when kernel==1; $k0 is overwritten.
- Interrupt entry:
  - flush=1, k0_we=1, k0_wdata=pc; the preempted instruction re-executes after jr $k0.
  - next pc=IRQ_VEC.
- j target: {pc_plus4[31:28], j_target, 2'b00}.
- Kernel-bit preservation:
  - For j and branch targets, bit 31 is forced to the current pc[31], so user code cannot enter kernel space.
  - For jr, bit 31 is forced to jr_target[31] when kernel==1 (return to user) and to 0 when kernel==0.
- Adders are 32-bit and wrap modulo 2^32 (0xFFFFFFFC+4 → 0x00000000). There is no overflow trap.
- hold==1: pc holds; flush=0, k0_we=0; the irq latch still captures.

## Timing
- Reset values: pc=RESET_PC, kernel=1, irq_pending=0, flush=0, k0_we=0, k0_wdata=0.
- pc updates one cycle after its inputs; flush, k0_we and k0_wdata are combinational in the entry cycle.
- Interrupt latency from irq assertion (user mode, no hold):
  - level mode: vector fetch on cycle N+1 after irq is sampled.
  - edge mode: vector fetch on cycle N+2.
- exc and irq in the same cycle: the exception wins. The interrupt stays pending and is re-evaluated once kernel returns to 0.
- rst_n asserted mid-entry: immediate return to reset values; the pending latch is cleared.

## Configuration
- PCSEQ_IRQ_EDGE_EN defined:
  - irq is registered, and a 0→1 transition sets the irq_pending flop.
  - The flop clears on the cycle the interrupt is accepted.
  - Further edges arriving while pending are merged.
- Not defined: level-sensitive. irq_pending = irq & kernel. No latch flop; pending equals the live irq level.

## Test plan
- Reset release → pc=0x80000000, kernel=1; after 3 cycles with no control inputs, pc=0x8000000C.
- jr_en=1, jr_target=0x000000F0 while in kernel → next pc=0x000000F0, kernel=0. Then j_en with j_target=0x03 → pc=0x0000000C.
- In user mode at pc=0x00000100, irq=1 → entry cycle flush=1, k0_we=1, k0_wdata=0x00000100; next pc=0x80000004. A second irq while in kernel is not taken.
- exc=1 at pc=0x00000200, with irq=1 in the same cycle → k0_wdata=0x00000204, pc=0x80000008. After jr to 0x00000204 the interrupt is taken at the next cycle.
- hold=1 for 4 cycles with br_taken=1 → pc unchanged, flush=0. Edge build only: an irq pulse during hold is latched and taken when hold drops.
- rst_n low during interrupt entry cycle → pc=0x80000000, irq_pending=0, k0_we=0 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and vector sequencer for the single-cycle MIPS core.
// Owns the fetch PC, picks the next PC (sequential/branch/jump/register-jump),
// and diverts fetch to the interrupt or exception vector, saving the return
// address to $k0 on every vector entry.
//
// Build option: define PCSEQ_IRQ_EDGE_EN for an edge-triggered, latched
// interrupt request. Without it the interrupt request is level-sensitive.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        irq,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_en,
    input  logic [25:0] j_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        k0_we,
    output logic [31:0] k0_wdata,
    output logic        kernel,
    output logic        irq_pending
);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] j_addr;
    logic        pend_cond;
    logic        take_irq;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign kernel   = pc_q[31];
    assign j_addr   = {pc_plus4[31:28], j_target, 2'b00};

    // Interrupts are masked in kernel mode, lose to a same-cycle exception
    // and are not taken while the sequencer is frozen.
    assign take_irq = pend_cond & ~kernel & ~exc & ~hold & rst_n;

`ifdef PCSEQ_IRQ_EDGE_EN
    logic irq_p1;
    logic pend_q;

    // Registered irq for edge detection; pending flop set on a rising edge,
    // cleared when the interrupt is accepted (edges while pending merge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_p1 <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_p1 <= irq;
            if (take_irq)
                pend_q <= 1'b0;
            else if (irq && !irq_p1)
                pend_q <= 1'b1;
        end
    end

    assign pend_cond   = pend_q;
    assign irq_pending = pend_q;
`else
    // Level mode: the live irq line is the pending condition; the status
    // output reports a request that is being held off by kernel mode.
    assign pend_cond   = irq;
    assign irq_pending = irq & kernel & rst_n;
`endif

    // Next-PC selection and vector-entry side effects, highest priority first.
    always_comb begin
        next_pc  = pc_plus4;
        flush    = 1'b0;
        k0_we    = 1'b0;
        k0_wdata = 32'd0;
        if (!rst_n || hold) begin
            next_pc = pc_q;
        end else if (exc) begin
            next_pc  = EXC_VEC;
            flush    = 1'b1;
            k0_we    = 1'b1;
            k0_wdata = pc_plus4;
        end else if (take_irq) begin
            next_pc  = IRQ_VEC;
            flush    = 1'b1;
            k0_we    = 1'b1;
            k0_wdata = pc_q;
        end else if (jr_en) begin
            // Only kernel code may choose the mode bit (return to user).
            next_pc = {kernel & jr_target[31], jr_target[30:0]};
        end else if (j_en) begin
            next_pc = {pc_q[31], j_addr[30:0]};
        end else if (br_taken) begin
            next_pc = {pc_q[31], br_target[30:0]};
        end
    end

    // PC register; the kernel bit is its MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= next_pc;
    end

endmodule
